// File: rtl/membus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : membus_arbiter_if
// Purpose  : Requester, memory-port and grant signals shared by the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface membus_arbiter_if;
    logic        cpu_en;
    logic        dbg_req;
    logic        d_req;
    logic        i_req;
    logic [31:0] dbg_adr;
    logic [31:0] d_adr;
    logic [31:0] i_adr;
    logic [31:0] dbg_wdata;
    logic [31:0] d_wdata;
    logic [3:0]  dbg_wren;
    logic [3:0]  d_wren;
    logic        dbg_ack;
    logic        d_ack;
    logic        i_ack;
    logic [31:0] rdata;
    logic        mem_op;
    logic [31:0] mem_adr;
    logic [31:0] mem_di;
    logic [3:0]  mem_wren;
    logic [31:0] mem_do;
    logic [2:0]  gnt;

    // Arbiter side
    modport slave (
        input  cpu_en, dbg_req, d_req, i_req,
        input  dbg_adr, d_adr, i_adr, dbg_wdata, d_wdata, dbg_wren, d_wren,
        input  mem_do,
        output dbg_ack, d_ack, i_ack, rdata,
        output mem_op, mem_adr, mem_di, mem_wren, gnt
    );

    // Requesters and memory side
    modport master (
        output cpu_en, dbg_req, d_req, i_req,
        output dbg_adr, d_adr, i_adr, dbg_wdata, d_wdata, dbg_wren, d_wren,
        output mem_do,
        input  dbg_ack, d_ack, i_ack, rdata,
        input  mem_op, mem_adr, mem_di, mem_wren, gnt
    );
endinterface
`default_nettype wire

// File: rtl/membus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : membus_arbiter
// Purpose  : Serialises dbg / dBus / iBus onto one synchronous memory port,
//            fixed priority dbg > d > i with an iBus anti-starvation guard.
// Revision : 1.0 - initial release
// ============================================================================
module membus_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  wire logic       clk,
    input  wire logic       reset,
    membus_arbiter_if.slave bus
);
    localparam int c_SW = $clog2(STARVE_LIMIT + 1);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ACCESS = 2'd1;
    localparam logic [1:0] c_RESP   = 2'd2;

    localparam logic [2:0] c_G_NONE = 3'b000;
    localparam logic [2:0] c_G_DBG  = 3'b100;
    localparam logic [2:0] c_G_D    = 3'b010;
    localparam logic [2:0] c_G_I    = 3'b001;

    localparam logic [c_SW-1:0] c_LIMIT = c_SW'(STARVE_LIMIT);
    localparam logic [c_SW-1:0] c_ONE   = c_SW'(1);

    logic [1:0]      r_state;
    logic [2:0]      r_gnt;
    logic [c_SW-1:0] r_streak;
    logic [31:0]     r_mem_adr;
    logic [31:0]     r_mem_di;
    logic [3:0]      r_mem_wren;

    logic [2:0] w_excl;
    logic       w_dbg_ok;
    logic       w_d_ok;
    logic       w_i_ok;
    logic [2:0] w_win;

    // The owner being acknowledged in RESP may not win the next slot.
    assign w_excl   = (r_state == c_RESP) ? r_gnt : c_G_NONE;
    assign w_dbg_ok = bus.dbg_req & ~w_excl[2];
    assign w_d_ok   = bus.d_req & bus.cpu_en & ~w_excl[1];
    assign w_i_ok   = bus.i_req & bus.cpu_en & ~w_excl[0];

    always_comb begin
        w_win = c_G_NONE;
        if (w_dbg_ok) begin
            w_win = c_G_DBG;
        end else if (w_i_ok && (r_streak == c_LIMIT)) begin
            w_win = c_G_I;
        end else if (w_d_ok) begin
            w_win = c_G_D;
        end else if (w_i_ok) begin
            w_win = c_G_I;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_IDLE;
            r_gnt      <= c_G_NONE;
            r_streak   <= '0;
            r_mem_adr  <= '0;
            r_mem_di   <= '0;
            r_mem_wren <= '0;
        end else begin
            case (r_state)
                c_ACCESS: begin
                    r_state <= c_RESP;
                end
                default: begin
                    if (w_win != c_G_NONE) begin
                        r_state <= c_ACCESS;
                        r_gnt   <= w_win;
                        if (w_win == c_G_DBG) begin
                            r_mem_adr  <= bus.dbg_adr;
                            r_mem_di   <= bus.dbg_wdata;
                            r_mem_wren <= bus.dbg_wren;
                        end else if (w_win == c_G_D) begin
                            r_mem_adr  <= bus.d_adr;
                            r_mem_di   <= bus.d_wdata;
                            r_mem_wren <= bus.d_wren;
                        end else begin
                            r_mem_adr  <= bus.i_adr;
                            r_mem_di   <= '0;
                            r_mem_wren <= '0;
                        end
                    end else begin
                        r_state <= c_IDLE;
                        r_gnt   <= c_G_NONE;
                    end

                    // Count dBus wins that kept a live iBus request waiting.
                    if ((w_win == c_G_D) && bus.i_req && bus.cpu_en) begin
                        if (r_streak != c_LIMIT) begin
                            r_streak <= r_streak + c_ONE;
                        end
                    end else if ((w_win == c_G_I) || !bus.i_req) begin
                        r_streak <= '0;
                    end
                end
            endcase
        end
    end

    assign bus.gnt      = r_gnt;
    assign bus.mem_op   = (r_state == c_ACCESS);
    assign bus.mem_adr  = r_mem_adr;
    assign bus.mem_di   = r_mem_di;
    assign bus.mem_wren = r_mem_wren;
    assign bus.rdata    = bus.mem_do;

    // Reset in the response cycle abandons the access, so the pulse is gated.
    assign bus.dbg_ack = (r_state == c_RESP) & r_gnt[2] & ~reset;
    assign bus.d_ack   = (r_state == c_RESP) & r_gnt[1] & ~reset;
    assign bus.i_ack   = (r_state == c_RESP) & r_gnt[0] & ~reset;
endmodule
`default_nettype wire

// File: tb/tb_membus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_membus_arbiter
// Purpose  : Transaction-level reference model with directed and random stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_membus_arbiter;
    localparam int c_LIMIT = 4;
    localparam int c_DBG   = 0;
    localparam int c_D     = 1;
    localparam int c_I     = 2;
    localparam int c_NONE  = 3;

    logic clk = 1'b0;
    logic reset;
    logic cpu_en;
    int   total = 0;
    int   bad   = 0;

    membus_arbiter_if bus();
    membus_arbiter #(.STARVE_LIMIT(c_LIMIT)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    // Requester agents
    logic        req   [3];
    logic [31:0] adr   [3];
    logic [31:0] wdata [3];
    logic [3:0]  wren  [3];
    bit          hold  [3];
    bit          allow_wr;
    logic        done  [3];
    int          rc;

    assign bus.cpu_en    = cpu_en;
    assign bus.dbg_req   = req[c_DBG];
    assign bus.d_req     = req[c_D];
    assign bus.i_req     = req[c_I];
    assign bus.dbg_adr   = adr[c_DBG];
    assign bus.d_adr     = adr[c_D];
    assign bus.i_adr     = adr[c_I];
    assign bus.dbg_wdata = wdata[c_DBG];
    assign bus.d_wdata   = wdata[c_D];
    assign bus.dbg_wren  = wren[c_DBG];
    assign bus.d_wren    = wren[c_D];

    function automatic logic [31:0] init_val(input int i);
        if (i == 64) return 32'hDEADBEEF;
        if (i == 16) return 32'h11223344;
        return (32'(i) * 32'h01010101) ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] m;
        m = old;
        for (int b = 0; b < 4; b++) if (be[b]) m[8*b +: 8] = nw[8*b +: 8];
        return m;
    endfunction

    // Synchronous memory driven by the DUT port
    logic [31:0] ram [256];
    logic [31:0] mem_do_r;
    bit          ram_ready = 1'b0;
    assign bus.mem_do = mem_do_r;

    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
            ram_ready <= 1'b1;
        end else if (bus.mem_op) begin
            mem_do_r <= ram[bus.mem_adr[9:2]];
            ram[bus.mem_adr[9:2]] <= merge(ram[bus.mem_adr[9:2]], bus.mem_di, bus.mem_wren);
        end
    end

    // Reference model: one transaction slot, owner, starvation count, shadow memory
    logic [31:0] ref_mem [256];
    bit          ref_ready = 1'b0;
    int          m_stage;   // 0 free, 1 memory strobe, 2 reply
    int          m_owner;
    int          m_streak;
    logic [31:0] m_adr, m_di, m_rd;
    logic [3:0]  m_wren;

    task automatic model_step();
        bit elig [3];
        int win;
        for (int r = 0; r < 3; r++) done[r] = (m_stage == 2) && (m_owner == r) && !reset;
        if (!ref_ready) begin
            for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
            ref_ready = 1'b1;
        end
        if (m_stage == 1) begin
            m_rd = ref_mem[m_adr[9:2]];
            ref_mem[m_adr[9:2]] = merge(m_rd, m_di, m_wren);
        end
        if (reset) begin
            m_stage = 0; m_owner = c_NONE; m_streak = 0;
            m_adr = '0; m_di = '0; m_wren = '0;
        end else if (m_stage == 1) begin
            m_stage = 2;
        end else begin
            for (int r = 0; r < 3; r++)
                elig[r] = req[r] && (r == c_DBG || cpu_en) && !(m_stage == 2 && m_owner == r);
            if (elig[c_DBG])                           win = c_DBG;
            else if (elig[c_I] && m_streak >= c_LIMIT) win = c_I;
            else if (elig[c_D])                        win = c_D;
            else if (elig[c_I])                        win = c_I;
            else                                       win = c_NONE;
            if (win == c_D && req[c_I] && cpu_en)      m_streak = (m_streak < c_LIMIT) ? m_streak + 1 : c_LIMIT;
            else if (win == c_I || !req[c_I])          m_streak = 0;
            if (win != c_NONE) begin
                m_stage = 1;
                m_owner = win;
                m_adr   = adr[win];
                m_di    = (win == c_I) ? 32'h0 : wdata[win];
                m_wren  = (win == c_I) ? 4'h0 : wren[win];
            end else begin
                m_stage = 0;
                m_owner = c_NONE;
            end
        end
    endtask

    initial begin
        m_stage = 0; m_owner = c_NONE; m_streak = 0;
        m_adr = '0; m_di = '0; m_wren = '0; m_rd = '0;
        for (int r = 0; r < 3; r++) done[r] = 1'b0;
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    bit chk_en = 1'b0;
    initial forever begin
        logic [2:0] eg;
        @(negedge clk);
        if (chk_en) begin
            case (m_owner)
                c_DBG:   eg = 3'b100;
                c_D:     eg = 3'b010;
                c_I:     eg = 3'b001;
                default: eg = 3'b000;
            endcase
            if (m_stage == 0) eg = 3'b000;
            check("mem_op",   bus.mem_op,   m_stage == 1);
            check("gnt",      bus.gnt,      eg);
            check("dbg_ack",  bus.dbg_ack,  m_stage == 2 && m_owner == c_DBG && !reset);
            check("d_ack",    bus.d_ack,    m_stage == 2 && m_owner == c_D && !reset);
            check("i_ack",    bus.i_ack,    m_stage == 2 && m_owner == c_I && !reset);
            check("mem_adr",  bus.mem_adr,  m_adr);
            check("mem_di",   bus.mem_di,   m_di);
            check("mem_wren", bus.mem_wren, m_wren);
            if (m_stage == 2 && !reset && m_wren == 4'h0) check("rdata", bus.rdata, m_rd);
        end
    end

    // Event log used by the directed literal checks
    int          first_ack [3];
    int          ack_cnt   [3];
    logic [31:0] last_rd   [3];
    int          opcnt;
    int          grant_log [$];

    function automatic int owner_of(input logic [2:0] g);
        case (g)
            3'b100:  return c_DBG;
            3'b010:  return c_D;
            3'b001:  return c_I;
            default: return c_NONE;
        endcase
    endfunction

    initial forever begin
        logic [2:0] a;
        @(negedge clk);
        a = {bus.i_ack, bus.d_ack, bus.dbg_ack};
        for (int r = 0; r < 3; r++) if (a[r]) begin
            if (first_ack[r] < 0) first_ack[r] = rc;
            ack_cnt[r]++;
            last_rd[r] = bus.rdata;
        end
        if (bus.mem_op) begin
            opcnt++;
            grant_log.push_back(owner_of(bus.gnt));
        end
    end

    task automatic clr_log();
        rc = 0;
        opcnt = 0;
        grant_log.delete();
        for (int r = 0; r < 3; r++) begin
            first_ack[r] = -1;
            ack_cnt[r]   = 0;
        end
    endtask

    task automatic new_req(input int r);
        req[r]   = 1'b1;
        adr[r]   = $urandom();
        wdata[r] = $urandom();
        if (r == c_I || !allow_wr || $urandom_range(0, 1) == 0) wren[r] = 4'h0;
        else wren[r] = 4'($urandom_range(0, 15));
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        rc++;
        for (int r = 0; r < 3; r++) if (done[r]) begin
            if (hold[r]) new_req(r);
            else req[r] = 1'b0;
        end
    endtask

    task automatic drain();
        for (int r = 0; r < 3; r++) hold[r] = 1'b0;
        repeat (12) tick();
    endtask

    task automatic raise_rd(input int r, input logic [31:0] a);
        req[r] = 1'b1; adr[r] = a; wdata[r] = '0; wren[r] = 4'h0;
    endtask

    int exp_seq [10];

    initial begin
        reset = 1'b1; cpu_en = 1'b1; allow_wr = 1'b0;
        for (int r = 0; r < 3; r++) begin
            req[r] = 1'b0; adr[r] = '0; wdata[r] = '0; wren[r] = '0; hold[r] = 1'b0;
        end
        clr_log();
        exp_seq = '{c_DBG, c_D, c_DBG, c_D, c_DBG, c_D, c_DBG, c_D, c_DBG, c_I};

        tick();
        chk_en = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        check("rst_gnt", bus.gnt, 3'b000);
        check("rst_mem_op", bus.mem_op, 1'b0);
        check("rst_mem_adr", bus.mem_adr, 32'h0);
        check("rst_acks", {bus.dbg_ack, bus.d_ack, bus.i_ack}, 3'b000);
        tick();
        reset = 1'b0;
        drain();

        // Single iBus read
        clr_log();
        raise_rd(c_I, 32'h100);
        tick();
        @(negedge clk);
        check("rd_c1_mem_op", bus.mem_op, 1'b1);
        check("rd_c1_gnt", bus.gnt, 3'b001);
        tick();
        @(negedge clk);
        check("rd_c2_i_ack", bus.i_ack, 1'b1);
        check("rd_c2_rdata", bus.rdata, 32'hDEADBEEF);
        check("rd_c2_gnt", bus.gnt, 3'b001);
        drain();

        // Simultaneous requests
        clr_log();
        raise_rd(c_DBG, 32'h10); raise_rd(c_D, 32'h20); raise_rd(c_I, 32'h30);
        repeat (8) tick();
        check("prio_dbg_ack", first_ack[c_DBG], 2);
        check("prio_d_ack", first_ack[c_D], 4);
        check("prio_i_ack", first_ack[c_I], 6);
        drain();

        // Starvation guard: dbg and d keep re-requesting, i waits
        clr_log();
        for (int r = 0; r < 3; r++) hold[r] = 1'b1;
        raise_rd(c_DBG, 32'h0); raise_rd(c_D, 32'h4); raise_rd(c_I, 32'h8);
        repeat (22) tick();
        check("starve_log_len", 32'(grant_log.size() >= 10), 1);
        if (grant_log.size() >= 10)
            for (int k = 0; k < 10; k++) check("starve_seq", grant_log[k], exp_seq[k]);
        check("starve_i_ack", first_ack[c_I], 20);
        drain();

        // Byte write then read-back
        clr_log();
        req[c_D] = 1'b1; adr[c_D] = 32'h40; wdata[c_D] = 32'h0000AB00; wren[c_D] = 4'b0010;
        tick();
        @(negedge clk);
        check("wr_c1_mem_op", bus.mem_op, 1'b1);
        check("wr_c1_wren", bus.mem_wren, 4'b0010);
        check("wr_c1_di", bus.mem_di, 32'h0000AB00);
        tick();
        @(negedge clk);
        check("wr_c2_d_ack", bus.d_ack, 1'b1);
        check("wr_c2_mem_op", bus.mem_op, 1'b0);
        tick();
        clr_log();
        raise_rd(c_D, 32'h40);
        repeat (4) tick();
        check("wr_rb_ack", first_ack[c_D], 2);
        check("wr_rb_data", last_rd[c_D], 32'h1122AB44);
        drain();

        // CPU halted: only dbg is served
        cpu_en = 1'b0;
        clr_log();
        raise_rd(c_D, 32'h50); raise_rd(c_I, 32'h54);
        repeat (6) tick();
        check("halt_ops", opcnt, 0);
        check("halt_acks", ack_cnt[c_D] + ack_cnt[c_I], 0);
        clr_log();
        raise_rd(c_DBG, 32'h58);
        repeat (4) tick();
        check("halt_dbg_ack", first_ack[c_DBG], 2);
        check("halt_cpu_acks", ack_cnt[c_D] + ack_cnt[c_I], 0);
        clr_log();
        cpu_en = 1'b1;
        repeat (6) tick();
        check("resume_d_ack", first_ack[c_D], 2);
        check("resume_i_ack", first_ack[c_I], 4);
        drain();

        // Reset during ACCESS abandons the access
        clr_log();
        raise_rd(c_D, 32'h60);
        tick();
        reset = 1'b1;
        @(negedge clk);
        check("rsta_c1_mem_op", bus.mem_op, 1'b1);
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("rsta_c2_mem_op", bus.mem_op, 1'b0);
        check("rsta_c2_gnt", bus.gnt, 3'b000);
        check("rsta_c2_d_ack", bus.d_ack, 1'b0);
        repeat (3) tick();
        check("rsta_reserve_ack", first_ack[c_D], 4);
        check("rsta_ack_cnt", ack_cnt[c_D], 1);
        drain();

        // Random traffic against the model
        allow_wr = 1'b1;
        repeat (3000) begin
            @(posedge clk);
            #2;
            for (int r = 0; r < 3; r++) begin
                if (done[r]) begin
                    if ($urandom_range(0, 1) == 0) new_req(r);
                    else req[r] = 1'b0;
                end else if (!req[r] && $urandom_range(0, 2) == 0) begin
                    new_req(r);
                end
            end
            if ($urandom_range(0, 24) == 0) cpu_en = ~cpu_en;
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 79) == 0) reset = 1'b1;
        end
        reset = 1'b0;
        cpu_en = 1'b1;
        drain();
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
